// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - ID-stage register read interface: {en, addr} requests and data returns
interface i_fetch_rreg #(
  parameter int DATA_W = 32
);
  logic [5:0]        r1_info;
  logic [5:0]        r2_info;
  logic [DATA_W-1:0] r1_data;
  logic [DATA_W-1:0] r2_data;

  modport master (output r1_info, r2_info, input r1_data, r2_data);
  modport slave  (input r1_info, r2_info, output r1_data, r2_data);
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - GPR file with two combinational read ports, one write-back port and HI/LO
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports and HI/LO.
module regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  i_fetch_rreg.slave        fetch,
  input  logic [DATA_W+5:0] wb_wreg_i,
  input  logic              wb_hilo_we_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam logic REG_ENABLE = 1'b1;

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  logic              w_en;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_en   = wb_wreg_i[DATA_W+5];
  assign w_addr = wb_wreg_i[DATA_W+4:DATA_W];
  assign w_data = wb_wreg_i[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (w_en == REG_ENABLE && w_addr != 5'd0) gpr[w_addr] <= w_data;
      if (wb_hilo_we_i) begin
        hi <= wb_hi_i;
        lo <= wb_lo_i;
      end
    end
  end

  // An undriven (X) enable fails the equality test and falls through to zero.
  function automatic logic [DATA_W-1:0] read_port(input logic [5:0] info);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!rst && info[5] == REG_ENABLE && info[4:0] != 5'd0) begin
      val = gpr[info[4:0]];
`ifdef REGFILE_BYPASS_EN
      if (w_en == REG_ENABLE && w_addr == info[4:0]) val = w_data;
`endif
    end
    return val;
  endfunction

  always_comb begin
    fetch.r1_data = read_port(fetch.r1_info);
    fetch.r2_data = read_port(fetch.r2_info);
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = hi;
      lo_o = lo;
`ifdef REGFILE_BYPASS_EN
      if (wb_hilo_we_i) begin
        hi_o = wb_hi_i;
        lo_o = wb_lo_i;
      end
`endif
    end
  end
endmodule
